// File: rtl/des_pkg.sv
// Shared widths, rotation schedule and permutation tables for the DES key schedule.
// Tables use DES bit numbering: entry value n selects input bit n, with bit 1 the MSB.
package des_pkg;
   localparam int KEY_W      = 64;
   localparam int HALF_W     = 28;
   localparam int CD_W       = 56;
   localparam int SUBKEY_W   = 48;
   localparam int NUM_ROUNDS = 16;

   typedef enum logic {IDLE, GEN} state_e;

   localparam int SHIFTS [1:16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

   localparam int PC1_TBL [0:55] = '{
      57, 49, 41, 33, 25, 17,  9,
       1, 58, 50, 42, 34, 26, 18,
      10,  2, 59, 51, 43, 35, 27,
      19, 11,  3, 60, 52, 44, 36,
      63, 55, 47, 39, 31, 23, 15,
       7, 62, 54, 46, 38, 30, 22,
      14,  6, 61, 53, 45, 37, 29,
      21, 13,  5, 28, 20, 12,  4};

   localparam int PC2_TBL [0:47] = '{
      14, 17, 11, 24,  1,  5,
       3, 28, 15,  6, 21, 10,
      23, 19, 12,  4, 26,  8,
      16,  7, 27, 20, 13,  2,
      41, 52, 31, 37, 47, 55,
      30, 40, 51, 45, 33, 48,
      44, 49, 39, 56, 34, 53,
      46, 42, 50, 36, 29, 32};

   function automatic logic [HALF_W-1:0] rotl(input logic [HALF_W-1:0] h, input int n);
      return (h << n) | (h >> (HALF_W - n));
   endfunction

   function automatic logic [HALF_W-1:0] rotr(input logic [HALF_W-1:0] h, input int n);
      return (h >> n) | (h << (HALF_W - n));
   endfunction
endpackage

// File: rtl/des_key_schedule_if.sv
// Load request and subkey stream between the key-schedule generator and its consumer.
interface des_key_schedule_if;
   import des_pkg::*;
   logic                start;
   logic [KEY_W-1:0]    key;
   logic                decrypt;
   logic                busy;
   logic [SUBKEY_W-1:0] subkey;
   logic                subkey_valid;
   logic                subkey_ready;
   logic [3:0]          round_idx;
   logic                done;

   modport slave  (input  start, key, decrypt, subkey_ready,
                   output busy, subkey, subkey_valid, round_idx, done);
   modport master (output start, key, decrypt, subkey_ready,
                   input  busy, subkey, subkey_valid, round_idx, done);
endinterface

// File: rtl/des_pc1.sv
// PC1: 64-bit key to 56-bit {C0,D0}, dropping the parity bits.
module des_pc1
   import des_pkg::*;
(
   input  logic [KEY_W-1:0] key,
   output logic [CD_W-1:0]  cd
);
   always_comb begin
      cd = '0;
      for (int i = 0; i < CD_W; i++) cd[CD_W-1-i] = key[KEY_W-PC1_TBL[i]];
   end
endmodule

// File: rtl/des_pc2.sv
// PC2: 56-bit {C,D} to the 48-bit round subkey.
module des_pc2
   import des_pkg::*;
(
   input  logic [CD_W-1:0]     cd,
   output logic [SUBKEY_W-1:0] subkey
);
   always_comb begin
      subkey = '0;
      for (int i = 0; i < SUBKEY_W; i++) subkey[SUBKEY_W-1-i] = cd[CD_W-PC2_TBL[i]];
   end
endmodule

// File: rtl/des_key_schedule.sv
// Sequential DES key schedule: one PC2 subkey per handshake, K1..K16 or K16..K1.
module des_key_schedule
   import des_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   des_key_schedule_if.slave  bus
);
   state_e            state_q, state_d;
   logic [HALF_W-1:0] c_q, c_d, d_q, d_d;
   logic [3:0]        count_q, count_d;
   logic              mode_q, mode_d;
   logic              done_q, done_d;
   logic [CD_W-1:0]     cd0;
   logic [SUBKEY_W-1:0] pc2_out;
   logic                gen;
   int                  idx;
   int                  sh;

   des_pc1 u_pc1 (.key(bus.key), .cd(cd0));
   des_pc2 u_pc2 (.cd({c_q, d_q}), .subkey(pc2_out));

   assign gen = (state_q == GEN);

   // Step toward the next round: encrypt uses the shift of round count+2 (the
   // halves already hold round count+1), decrypt undoes the shift of round 16-count.
   always_comb begin
      idx = mode_q ? (16 - int'(count_q)) : (int'(count_q) + 2);
      if (idx > 16) idx = 16;
      sh = SHIFTS[idx];
   end

   always_comb begin
      state_d = state_q;
      c_d     = c_q;
      d_d     = d_q;
      count_d = count_q;
      mode_d  = mode_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: if (bus.start) begin
            c_d     = bus.decrypt ? cd0[CD_W-1:HALF_W] : rotl(cd0[CD_W-1:HALF_W], 1);
            d_d     = bus.decrypt ? cd0[HALF_W-1:0]    : rotl(cd0[HALF_W-1:0], 1);
            count_d = 4'd0;
            mode_d  = bus.decrypt;
            state_d = GEN;
         end
         GEN: if (bus.subkey_ready) begin
            if (count_q == 4'd15) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end else begin
               count_d = count_q + 4'd1;
               c_d     = mode_q ? rotr(c_q, sh) : rotl(c_q, sh);
               d_d     = mode_q ? rotr(d_q, sh) : rotl(d_q, sh);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         c_q     <= '0;
         d_q     <= '0;
         count_q <= '0;
         mode_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         c_q     <= c_d;
         d_q     <= d_d;
         count_q <= count_d;
         mode_q  <= mode_d;
         done_q  <= done_d;
      end
   end

   assign bus.busy         = gen;
   assign bus.subkey_valid = gen;
   assign bus.subkey       = gen ? pc2_out : '0;
   assign bus.round_idx    = !gen ? 4'd0 : (mode_q ? (4'd15 - count_q) : count_q);
   assign bus.done         = done_q;
endmodule
